// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
// The FSM state enum, the default divider value and the register width live here.
package uart_pkg;

  localparam int DEFAULT_CLK_DIV = 139;
  localparam int DAT_WIDTH       = 32;
  localparam int BYTE_WIDTH      = 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Zero-extends a byte to the width of the simpleuart data register.
  function automatic logic [DAT_WIDTH-1:0] pad_byte(input logic [BYTE_WIDTH-1:0] b);
    return {{(DAT_WIDTH - BYTE_WIDTH){1'b0}}, b};
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Byte stream into the feeder: valid/ready handshake with 8-bit data.
// The producer holds the master modport and the feeder holds the slave modport.
interface uart_tx_feeder_if;
  import uart_pkg::*;

  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with pointers carrying one extra wrap bit.
// Head is read straight from storage, so it is valid whenever the FIFO is non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the pointer difference is the occupancy directly.
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes from a valid/ready producer and feeds them to simpleuart's data register.
// Programs the simpleuart divider once after every reset before any byte is sent.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_feeder_if.slave        src,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [3:0]             div_we,
  output logic [DAT_WIDTH-1:0]   div_di,
  output logic                   dat_we,
  output logic [DAT_WIDTH-1:0]   dat_di,
  input  logic                   dat_wait
);

  state_t                state_reg;
  state_t                state_next;

  logic [BYTE_WIDTH-1:0] head;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  accept;

  logic [3:0]            div_we_reg,   div_we_next;
  logic [DAT_WIDTH-1:0]  div_di_reg,   div_di_next;
  logic                  dat_we_reg,   dat_we_next;
  logic [DAT_WIDTH-1:0]  dat_di_reg,   dat_di_next;
  logic                  overflow_reg, overflow_next;

  sync_fifo #(
    .WIDTH (BYTE_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (src.in_valid),
    .push_data (src.in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign src.in_ready = !full;

  // The only pop is the load into dat_di, so the byte in flight is never counted in level.
  assign pop    = (state_reg == ST_IDLE) && !empty;
  assign accept = dat_we_reg && !dat_wait;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_INIT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: state_next = ST_IDLE;
      ST_IDLE: if (!empty) state_next = ST_SEND;
      ST_SEND: if (accept) state_next = ST_IDLE;
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    div_we_next   = 4'h0;
    div_di_next   = '0;
    dat_we_next   = dat_we_reg;
    dat_di_next   = dat_di_reg;
    // A push attempt while full is lost even if a pop frees a slot on the same edge.
    overflow_next = overflow_reg | (src.in_valid && !src.in_ready);
    case (state_reg)
      ST_INIT: begin
        div_we_next = 4'hF;
        div_di_next = DAT_WIDTH'(CLK_DIV);
        dat_we_next = 1'b0;
      end
      ST_IDLE: begin
        if (!empty) begin
          dat_we_next = 1'b1;
          dat_di_next = pad_byte(head);
        end else begin
          dat_we_next = 1'b0;
        end
      end
      ST_SEND: begin
        if (accept) dat_we_next = 1'b0;
      end
      default: dat_we_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_we_reg   <= 4'h0;
      div_di_reg   <= '0;
      dat_we_reg   <= 1'b0;
      dat_di_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      div_we_reg   <= div_we_next;
      div_di_reg   <= div_di_next;
      dat_we_reg   <= dat_we_next;
      dat_di_reg   <= dat_di_next;
      overflow_reg <= overflow_next;
    end
  end

  assign div_we   = div_we_reg;
  assign div_di   = div_di_reg;
  assign dat_we   = dat_we_reg;
  assign dat_di   = dat_di_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: simpleuart wait model, queue-based reference model and directed steps.
// Every accepted byte is printed on its own line.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  level;
  logic        overflow;
  logic [3:0]  div_we;
  logic [31:0] div_di;
  logic        dat_we;
  logic [31:0] dat_di;
  logic        dat_wait;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  uart_tx_feeder_if src ();

  uart_tx_feeder #(.DEPTH(DEPTH), .CLK_DIV(139)) dut (
    .clk      (clk),
    .reset    (reset),
    .src      (src.slave),
    .level    (level),
    .overflow (overflow),
    .div_we   (div_we),
    .div_di   (div_di),
    .dat_we   (dat_we),
    .dat_di   (dat_di),
    .dat_wait (dat_wait)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // simpleuart model: each byte sees wait high for a set number of SEND cycles, or forever while hold is set
  logic hold      = 1'b0;
  int   len       = 0;
  bit   rand_mode = 1'b0;
  int   rnd_len   = 0;
  int   wcnt      = 0;

  assign dat_wait = dat_we && (hold || (wcnt < (rand_mode ? rnd_len : len)));

  always @(posedge clk) begin
    if (dat_we) begin
      if (dat_wait) wcnt <= wcnt + 1;
      else begin
        wcnt    <= 0;
        rnd_len <= $urandom_range(0, 20);
      end
    end
  end

  // Reference model: the queue holds buffered bytes in push order; its size is the expected level
  logic [7:0] exp_q[$];
  logic [7:0] acc_log[$];
  bit         push_pending = 1'b0;
  logic [7:0] push_data_pending = 8'h00;
  bit         rst_pending = 1'b1;
  bit         prev_we = 1'b0;
  bit         ov_model = 1'b0;
  bit         accept_prev = 1'b0;
  int         acc_total = 0;
  int         div_pulses = 0;

  always @(negedge clk) begin
    if (rst_pending) begin
      exp_q.delete();
      ov_model     = 1'b0;
      push_pending = 1'b0;
    end else begin
      if (dat_we && !prev_we) begin
        chk("load_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("load_order", dat_di, {24'h0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
      if (accept_prev) chk("we_drop_after_accept", 32'(dat_we), 32'd0);
      if (push_pending) exp_q.push_back(push_data_pending);
    end
    prev_we = dat_we;
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("in_ready", 32'(src.in_ready), 32'(exp_q.size() < DEPTH));
    chk("overflow", 32'(overflow), 32'(ov_model));
    chk("dat_di_upper", 32'(dat_di[31:8]), 32'd0);
    if (div_we != 4'h0) begin
      div_pulses++;
      chk("div_we_value", 32'(div_we), 32'hF);
    end
    rst_pending  = reset;
    accept_prev  = 1'b0;
    push_pending = 1'b0;
    if (!reset) begin
      push_pending      = src.in_valid && (exp_q.size() < DEPTH);
      push_data_pending = src.in_data;
      if (src.in_valid && exp_q.size() >= DEPTH) ov_model = 1'b1;
      if (dat_we && !dat_wait) begin
        accept_prev = 1'b1;
        acc_total++;
        acc_log.push_back(dat_di[7:0]);
        $display("accept %0d: data=0x%02h level=%0d t=%0t", acc_total, dat_di[7:0], level, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (acc_total < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(acc_total >= target), 32'd1);
  endtask

  logic [7:0] hello[13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                            8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
  logic [7:0] x[18];
  logic [7:0] sent[$];

  initial begin
    int   base;
    int   n;
    int   peak;
    int   gap;
    int   acc_before;
    logic rdy;
    logic [7:0] b;

    reset        = 1'b1;
    src.in_valid = 1'b0;
    src.in_data  = 8'h00;
    repeat (3) tick();
    chk("rst_div_we", 32'(div_we), 32'd0);
    chk("rst_div_di", div_di, 32'd0);
    chk("rst_dat_we", 32'(dat_we), 32'd0);
    chk("rst_dat_di", dat_di, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(src.in_ready), 32'd1);

    // Divider programmed on the first edge out of reset, for one cycle only
    reset = 1'b0;
    tick();
    chk("init_div_we", 32'(div_we), 32'hF);
    chk("init_div_di", div_di, 32'd139);
    tick();
    chk("init_div_we_off", 32'(div_we), 32'd0);
    chk("init_div_di_off", div_di, 32'd0);

    // Single byte, wait never raised
    len = 0;
    repeat (3) tick();
    src.in_data  = 8'h48;
    src.in_valid = 1'b1;
    tick();
    src.in_valid = 1'b0;
    chk("single_level", 32'(level), 32'd1);
    n = 0;
    while (!dat_we && n < 2) begin
      tick();
      n++;
    end
    chk("single_dat_we", 32'(dat_we), 32'd1);
    chk("single_dat_di", dat_di, 32'h48);
    chk("single_wait_low", 32'(dat_wait), 32'd0);
    tick();
    chk("single_we_drop", 32'(dat_we), 32'd0);

    // Hello World with a frame-length wait per byte
    len = 1390;
    repeat (2) tick();
    base = acc_log.size();
    peak = 0;
    for (int i = 0; i < 13; i++) begin
      src.in_data  = hello[i];
      src.in_valid = 1'b1;
      tick();
      if (int'(level) > peak) peak = int'(level);
    end
    src.in_valid = 1'b0;
    chk("hello_peak", 32'(peak), 32'd12);
    wait_accepts(base + 13, 13 * 1400 + 200, "hello_drain");
    for (int i = 0; i < 13; i++)
      if (base + i < acc_log.size()) chk("hello_order", 32'(acc_log[base + i]), 32'(hello[i]));
    chk("hello_level_end", 32'(level), 32'd0);

    // Overflow: 18 pushes while the UART never drops wait
    hold = 1'b1;
    len  = 3;
    repeat (4) tick();
    base = acc_log.size();
    for (int i = 0; i < 18; i++) begin
      x[i]         = 8'($urandom);
      src.in_data  = x[i];
      src.in_valid = 1'b1;
      tick();
      if (i == 16) begin
        chk("ovf_full_level", 32'(level), 32'd16);
        chk("ovf_full_ready", 32'(src.in_ready), 32'd0);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
      end
    end
    src.in_valid = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_dat_we", 32'(dat_we), 32'd1);
    chk("ovf_dat_di", dat_di, {24'h0, x[0]});
    hold = 1'b0;
    wait_accepts(base + 17, 17 * 10 + 50, "ovf_drain");
    repeat (20) tick();
    chk("ovf_sent_count", 32'(acc_log.size() - base), 32'd17);
    for (int i = 0; i < 17; i++)
      if (base + i < acc_log.size()) chk("ovf_order", 32'(acc_log[base + i]), 32'(x[i]));
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_level_end", 32'(level), 32'd0);

    // Random gaps and random wait lengths, pointers wrap several times
    rand_mode = 1'b1;
    base = acc_log.size();
    peak = 0;
    sent.delete();
    for (int i = 0; i < 100; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      b            = 8'($urandom);
      src.in_data  = b;
      src.in_valid = 1'b1;
      n = 0;
      do begin
        rdy = src.in_ready;
        tick();
        n++;
        if (int'(level) > peak) peak = int'(level);
      end while (!rdy && n < 200);
      src.in_valid = 1'b0;
      chk("rand_push_done", 32'(rdy), 32'd1);
      sent.push_back(b);
    end
    wait_accepts(base + 100, 100 * 30, "rand_drain");
    for (int i = 0; i < 100; i++)
      if (base + i < acc_log.size()) chk("rand_order", 32'(acc_log[base + i]), 32'(sent[i]));
    chk("rand_level_max", 32'(peak <= 16), 32'd1);
    rand_mode = 1'b0;

    // Reset during SEND with wait high and five bytes buffered
    hold = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 6; i++) begin
      src.in_data  = 8'(8'hA0 + i);
      src.in_valid = 1'b1;
      tick();
    end
    src.in_valid = 1'b0;
    chk("mid_level", 32'(level), 32'd5);
    chk("mid_dat_we", 32'(dat_we), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_dat_we", 32'(dat_we), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_in_ready", 32'(src.in_ready), 32'd1);
    chk("mid_rst_div_we", 32'(div_we), 32'd0);
    reset = 1'b0;
    tick();
    chk("reinit_div_we", 32'(div_we), 32'hF);
    chk("reinit_div_di", div_di, 32'd139);
    hold = 1'b0;
    tick();
    chk("reinit_div_we_off", 32'(div_we), 32'd0);
    acc_before = acc_total;
    repeat (30) tick();
    chk("mid_discarded", 32'(acc_total), 32'(acc_before));

    while (cyc < 10500) tick();
    chk("div_pulse_total", 32'(div_pulses), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
